// File: rtl/ccl_scan_sequencer.sv
// Frame-buffer sequencer for connected-component labeling: captures a masked frame into the
// mask BRAM, then raster-scans it with W/NW/N/NE read addresses and a latency-aligned pixel
// stream. Optional capture watchdog enabled by defining CCL_CAPTURE_TIMEOUT_EN.
module ccl_scan_sequencer #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 180,
  parameter int unsigned RD_LATENCY = 2,
`ifdef CCL_CAPTURE_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
`endif
  localparam int unsigned AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          new_frame_in,
  input  logic          valid_in,
  input  logic [10:0]   x_in,
  input  logic [9:0]    y_in,
  input  logic          mask_in,
  output logic          wr_en_out,
  output logic [AW-1:0] wr_addr_out,
  output logic          wr_data_out,
  output logic          rd_en_out,
  output logic [AW-1:0] cur_addr_out,
  output logic [AW-1:0] w_addr_out,
  output logic [AW-1:0] nw_addr_out,
  output logic [AW-1:0] n_addr_out,
  output logic [AW-1:0] ne_addr_out,
  input  logic          ready_in,
  output logic          pix_valid_out,
  output logic [10:0]   pix_x_out,
  output logic [9:0]    pix_y_out,
  output logic [3:0]    nbr_exists_out,
  output logic          last_out,
  output logic          busy_out,
  output logic          frame_done_out,
  output logic          overrun_out
`ifdef CCL_CAPTURE_TIMEOUT_EN
  ,
  output logic          timeout_out
`endif
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;

  typedef enum logic [2:0] {IDLE, CAPTURE, SCAN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic          valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    exists;
    logic          last;
  } tag_t;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] cur_q, cur_d;
  tag_t          pipe_q [RD_LATENCY];
  tag_t          push_tag;
  tag_t          tail;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_data_q, wr_data_d;
  logic          busy_q, frame_done_q, overrun_q;
  logic          in_range, wr_fire, last_in_pix, x_edge, scan_last, scanning;
  logic          rd_en, tail_take, timeout_hit;
  logic [3:0]    exists;

  assign tail        = pipe_q[RD_LATENCY-1];
  assign in_range    = (x_in < XW'(WIDTH)) && (y_in < YW'(HEIGHT));
  assign last_in_pix = (x_in == XW'(WIDTH - 1)) && (y_in == YW'(HEIGHT - 1));
  assign x_edge      = (x_q == XW'(WIDTH - 1));
  assign scan_last   = x_edge && (y_q == YW'(HEIGHT - 1));
  assign scanning    = (state_q == SCAN);
  // {w, nw, n, ne} inside-frame flags for the counter pixel
  assign exists      = {x_q != '0, (x_q != '0) && (y_q != '0), y_q != '0, (y_q != '0) && !x_edge};
  // BRAM enable doubles as pipeline advance so read data and tags stay aligned under stall
  assign rd_en       = ((state_q == SCAN) || (state_q == DRAIN)) && (ready_in || !tail.valid);
  assign tail_take   = tail.valid && ready_in;
  assign wr_fire     = (state_q == CAPTURE) && valid_in && in_range && !timeout_hit;

`ifdef CCL_CAPTURE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;

  assign timeout_hit = (state_q == CAPTURE) && (to_cnt_q == TW'(TIMEOUT_CYCLES));

  // Cycles since the last pixel strobe (or since the start-of-frame strobe)
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE) begin
      to_cnt_d = TW'(1);
    end else if (state_q == CAPTURE) begin
      to_cnt_d = valid_in ? TW'(1) : to_cnt_q + TW'(1);
    end
    timeout_d = (state_d == CAPTURE) && (to_cnt_d == TW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_out = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cur_d     = cur_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    push_tag  = '0;
    case (state_q)
      IDLE: begin
        if (new_frame_in) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (wr_fire) begin
          wr_en_d   = 1'b1;
          wr_addr_d = AW'(y_in) * AW'(WIDTH) + AW'(x_in);
          wr_data_d = mask_in;
          if (last_in_pix) begin
            state_d = SCAN;
            x_d     = '0;
            y_d     = '0;
            cur_d   = '0;
          end
        end
      end
      SCAN: begin
        if (rd_en) begin
          push_tag.valid  = 1'b1;
          push_tag.x      = x_q;
          push_tag.y      = y_q;
          push_tag.exists = exists;
          push_tag.last   = scan_last;
          if (scan_last) begin
            state_d = DRAIN;
            x_d     = '0;
            y_d     = '0;
            cur_d   = '0;
          end else begin
            cur_d = cur_q + AW'(1);
            if (x_edge) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (tail_take && tail.last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cur_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cur_q        <= cur_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
      overrun_q    <= new_frame_in && (state_q != IDLE);
      if (rd_en) begin
        pipe_q[0] <= push_tag;
        for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign rd_en_out      = rd_en;
  // Out-of-frame neighbours read address 0; their exists flag masks the data downstream
  assign cur_addr_out   = scanning ? cur_q : '0;
  assign w_addr_out     = (scanning && exists[3]) ? cur_q - AW'(1) : '0;
  assign nw_addr_out    = (scanning && exists[2]) ? cur_q - AW'(WIDTH + 1) : '0;
  assign n_addr_out     = (scanning && exists[1]) ? cur_q - AW'(WIDTH) : '0;
  assign ne_addr_out    = (scanning && exists[0]) ? cur_q - AW'(WIDTH - 1) : '0;
  assign pix_valid_out  = tail.valid;
  assign pix_x_out      = tail.x;
  assign pix_y_out      = tail.y;
  assign nbr_exists_out = tail.exists;
  assign last_out       = tail.last;
  assign busy_out       = busy_q;
  assign frame_done_out = frame_done_q;
  assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_ccl_scan_sequencer.sv
// Directed bench for ccl_scan_sequencer on a 4x3 frame with a 2-cycle read latency.
module tb_ccl_scan_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       new_frame_in, valid_in, mask_in, ready_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic       wr_en_out, wr_data_out, rd_en_out;
  logic [3:0] wr_addr_out, cur_addr_out, w_addr_out, nw_addr_out, n_addr_out, ne_addr_out;
  logic       pix_valid_out, last_out, busy_out, frame_done_out, overrun_out;
  logic [10:0] pix_x_out;
  logic [9:0]  pix_y_out;
  logic [3:0]  nbr_exists_out;
`ifdef CCL_CAPTURE_TIMEOUT_EN
  logic       timeout_out;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  ccl_scan_sequencer #(
    .WIDTH(4), .HEIGHT(3), .RD_LATENCY(2)
`ifdef CCL_CAPTURE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_frame_in(new_frame_in), .valid_in(valid_in),
    .x_in(x_in), .y_in(y_in), .mask_in(mask_in), .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .rd_en_out(rd_en_out),
    .cur_addr_out(cur_addr_out), .w_addr_out(w_addr_out), .nw_addr_out(nw_addr_out),
    .n_addr_out(n_addr_out), .ne_addr_out(ne_addr_out), .ready_in(ready_in),
    .pix_valid_out(pix_valid_out), .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
    .nbr_exists_out(nbr_exists_out), .last_out(last_out), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .overrun_out(overrun_out)
`ifdef CCL_CAPTURE_TIMEOUT_EN
    , .timeout_out(timeout_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {w,nw,n,ne} flags for a 4x3 frame
  function automatic logic [3:0] exp_exists(input int x, input int y);
    return {x != 0, (x != 0) && (y != 0), y != 0, (y != 0) && (x != 3)};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, wr_en_out, 0);
    check({tag, "_rd_en"}, rd_en_out, 0);
    check({tag, "_cur"}, cur_addr_out, 0);
    check({tag, "_nbr_addr"}, {w_addr_out, nw_addr_out, n_addr_out, ne_addr_out}, 0);
    check({tag, "_pix"}, {pix_valid_out, pix_x_out, pix_y_out, nbr_exists_out, last_out}, 0);
    check({tag, "_status"}, {busy_out, frame_done_out, overrun_out}, 0);
  endtask

  // Start a frame and write all 12 pixels in raster order, mask=1 only at (1,1)
  task automatic capture_frame(input bit with_oob);
    new_frame_in = 1'b1;
    @(posedge clk_in); #2;
    new_frame_in = 1'b0;
    check("sof_busy", busy_out, 1);
    if (with_oob) begin
      valid_in = 1'b1; x_in = 11'd4; y_in = 10'd0; mask_in = 1'b1;
      @(posedge clk_in); #2;
      check("oob_x_dropped", wr_en_out, 0);
      x_in = 11'd0; y_in = 10'd3;
      @(posedge clk_in); #2;
      check("oob_y_dropped", wr_en_out, 0);
    end
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        valid_in = 1'b1; x_in = 11'(x); y_in = 10'(y); mask_in = (x == 1) && (y == 1);
        @(posedge clk_in); #2;
        check("wr_en", wr_en_out, 1);
        check("wr_addr", wr_addr_out, y * 4 + x);
        check("wr_data", wr_data_out, (x == 1) && (y == 1));
        if (x == 1 && y == 1) check("wr_pix11", {wr_addr_out, wr_data_out}, {4'd5, 1'b1});
        if (x == 2 && y == 2) check("still_capture", rd_en_out, 0);
      end
    end
    valid_in = 1'b0;
    check("scan_entry_rd_en", rd_en_out, 1);
    check("scan_entry_cur", cur_addr_out, 0);
    check("scan_entry_nbr", {w_addr_out, nw_addr_out, n_addr_out, ne_addr_out}, 0);
  endtask

  // Cycle k counts samples after SCAN entry; checks consumption order and timing
  task automatic run_scan(input int stall_at, input int stall_len, input int ovr_at,
                          input int exp_done);
    int idx = 0;
    int k = 0;
    int first_v = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    bit fin = 1'b0;
    logic [10:0] sx = '0;
    logic [9:0]  sy = '0;
    while (!fin && k < 100) begin
      @(posedge clk_in); #1;
      k++;
      ready_in     = !(stall_at > 0 && k >= stall_at && k < stall_at + stall_len);
      new_frame_in = (k == ovr_at);
      #1;
      if (ovr_at > 0 && k == ovr_at + 1) check("overrun_pulse", overrun_out, 1);
      if (ovr_at > 0 && k == ovr_at + 2) check("overrun_single", overrun_out, 0);
      if (!ready_in) begin
        check("stall_rd_en", rd_en_out, 0);
        if (k == stall_at) begin
          sx = pix_x_out; sy = pix_y_out;
        end else begin
          check("stall_frozen", {pix_x_out, pix_y_out}, {sx, sy});
        end
      end
      if (stall_at == 0 && k == 5)
        check("addr_px11", {cur_addr_out, w_addr_out, nw_addr_out, n_addr_out, ne_addr_out},
              {4'd5, 4'd4, 4'd0, 4'd1, 4'd2});
      if (stall_at == 0 && k == 7)
        check("addr_px31", {cur_addr_out, w_addr_out, nw_addr_out, n_addr_out, ne_addr_out},
              {4'd7, 4'd6, 4'd2, 4'd3, 4'd0});
      if (pix_valid_out && first_v < 0) first_v = k;
      if (pix_valid_out && ready_in) begin
        check("pix_xy", {pix_x_out, pix_y_out}, {11'(idx % 4), 10'(idx / 4)});
        check("pix_exists", nbr_exists_out, exp_exists(idx % 4, idx / 4));
        check("pix_last", last_out, idx == 11);
        if (idx == 0) check("px00_exists", nbr_exists_out, 4'b0000);
        if (idx == 5) check("px11_exists", nbr_exists_out, 4'b1111);
        if (idx == 7) check("px31_exists", nbr_exists_out, 4'b1110);
        idx++;
      end
      if (frame_done_out) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        check("post_done_busy", busy_out, 0);
        check("post_done_pulse", frame_done_out, 0);
        fin = 1'b1;
      end
    end
    ready_in = 1'b1;
    new_frame_in = 1'b0;
    check("scan_finished", fin, 1);
    check("first_valid_cycle", first_v, 2);
    check("done_cycle", done_cyc, exp_done);
    check("done_count", done_cnt, 1);
    check("pixels_consumed", idx, 12);
  endtask

  initial begin
    rst_in = 1'b1; new_frame_in = 1'b0; valid_in = 1'b0; mask_in = 1'b0;
    x_in = '0; y_in = '0; ready_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #2;
    check_all_zero("reset");
    rst_in = 1'b0;
    @(posedge clk_in); #2;
    check("idle_busy", busy_out, 0);

    // Frame 1: out-of-range drops, free-running scan, overrun strobe mid-scan
    capture_frame(1'b1);
    run_scan(0, 0, 3, 14);

    // Frame 2: datapath back-pressure for 5 cycles
    capture_frame(1'b0);
    run_scan(6, 5, 0, 19);

    // Frame 3: asynchronous reset mid-scan, then a clean frame
    capture_frame(1'b0);
    repeat (4) begin @(posedge clk_in); #2; end
    check("pre_reset_valid", pix_valid_out, 1);
    #2 rst_in = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk_in); #2;
    rst_in = 1'b0;
    begin
      int dones = 0;
      repeat (20) begin
        @(posedge clk_in); #2;
        if (frame_done_out) dones++;
      end
      check("no_done_after_reset", dones, 0);
      check("idle_after_reset", busy_out, 0);
    end
    capture_frame(1'b0);
    run_scan(0, 0, 0, 14);

`ifdef CCL_CAPTURE_TIMEOUT_EN
    new_frame_in = 1'b1;
    @(posedge clk_in); #2;
    new_frame_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; x_in = 11'(i % 4); y_in = 10'(i / 4); mask_in = 1'b0;
      @(posedge clk_in); #2;
    end
    valid_in = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      check("timeout_pulse", timeout_out, j == 10);
      check("timeout_busy", busy_out, j <= 10);
      @(posedge clk_in); #2;
    end
    check("timeout_no_scan", rd_en_out, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

endmodule
